// File: rtl/ceespu_int_ctrl.sv
// ---------------------------------------------------------------------------
// ceespu_int_ctrl
//
// Four-source interrupt controller for the Ceespu core. Rising edges on the
// peripheral request lines latch into a pending register. Any pending source
// that is also enabled in the mask raises a single registered interrupt
// request towards decode, together with the index of the winning source.
// Source 0 has the highest priority.
//
// A small three-state machine sequences each request:
//   IDLE - waiting for an enabled pending source
//   REQ  - O_int asserted, vector frozen until ack or withdrawal
//   GAP  - one dead cycle after an ack so decode never sees back-to-back
//          requests without a gap
//
// Ports
//   I_clk         system clock, all state changes on the rising edge
//   I_rst_n       asynchronous active-low reset
//   I_irq[3:0]    peripheral request lines (events are rising edges)
//   I_int_ack     one-cycle pulse from decode: interrupt has been taken
//   I_memE        register access strobe
//   I_memWe       1 = write, 0 = read (only meaningful with I_memE)
//   I_addr[1:0]   0 = MASK, 1 = PENDING (write-1-to-clear), 2 = STATUS,
//                 3 = reserved
//   I_data[31:0]  write data, only bits [3:0] are used
//   O_data[31:0]  registered read data, held between reads
//   O_int         interrupt request to decode
//   O_int_vector  index of the requesting source, stable while O_int = 1
// ---------------------------------------------------------------------------
module ceespu_int_ctrl (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [3:0]  I_irq,
  input  logic        I_int_ack,
  input  logic        I_memE,
  input  logic        I_memWe,
  input  logic [1:0]  I_addr,
  input  logic [31:0] I_data,
  output logic [31:0] O_data,
  output logic        O_int,
  output logic [1:0]  O_int_vector
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;

  state_t      state_q, state_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  prev_irq_q, prev_irq_d;
  logic        int_q, int_d;
  logic [1:0]  vec_q, vec_d;
  logic [31:0] data_q, data_d;

  logic [3:0]  irq_edge;
  logic [3:0]  active;
  logic [3:0]  ack_clr;
  logic [3:0]  w1c_clr;
  logic        reg_wr;
  logic        reg_rd;
  logic [1:0]  lowest_active;

  // Upper write-data bits carry no meaning for this block.
  logic unused_data;
  assign unused_data = ^I_data[31:4];

  assign reg_wr   = I_memE & I_memWe;
  assign reg_rd   = I_memE & ~I_memWe;

  // A source fires only on a 0->1 transition seen across two edges.
  assign irq_edge = I_irq & ~prev_irq_q;

  // Only sources that are both latched and enabled compete for the request.
  assign active   = pending_q & mask_q;

  // Fixed priority: the lowest numbered active source wins.
  always_comb begin
    lowest_active = 2'd3;
    if (active[0]) begin
      lowest_active = 2'd0;
    end else if (active[1]) begin
      lowest_active = 2'd1;
    end else if (active[2]) begin
      lowest_active = 2'd2;
    end
  end

  // Request sequencer. The vector is latched only on the IDLE->REQ step so a
  // higher-priority source arriving later cannot preempt an open request.
  // A request is withdrawn when its source is masked off or its pending bit
  // has been cleared by software; an ack takes precedence over withdrawal.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ack_clr = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (|active) begin
          state_d = ST_REQ;
          vec_d   = lowest_active;
        end
      end
      ST_REQ: begin
        if (I_int_ack) begin
          ack_clr = 4'b0001 << vec_q;
          state_d = ST_GAP;
        end else if (!mask_q[vec_q] || !pending_q[vec_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    int_d = (state_d == ST_REQ);
  end

  // Register file writes and the pending update. Clears from an ack or a
  // write-1-to-clear are applied first and new edges are OR-ed in last, so a
  // simultaneous set on the same bit always survives.
  always_comb begin
    mask_d     = mask_q;
    w1c_clr    = 4'b0000;
    prev_irq_d = I_irq;
    if (reg_wr && (I_addr == ADDR_MASK)) begin
      mask_d = I_data[3:0];
    end
    if (reg_wr && (I_addr == ADDR_PENDING)) begin
      w1c_clr = I_data[3:0];
    end
    pending_d = (pending_q & ~(ack_clr | w1c_clr)) | irq_edge;
  end

  // Read mux. Reads return the register contents as they stood before the
  // access edge; the result is held until the next read.
  always_comb begin
    data_d = data_q;
    if (reg_rd) begin
      case (I_addr)
        ADDR_MASK:    data_d = {28'b0, mask_q};
        ADDR_PENDING: data_d = {28'b0, pending_q};
        ADDR_STATUS:  data_d = {26'b0, state_q, int_q, 1'b0, vec_q};
        default:      data_d = 32'b0;
      endcase
    end
  end

  // prev_irq resets to all ones so a line already high when reset releases
  // is not mistaken for a fresh event.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= ST_IDLE;
      mask_q     <= 4'b0000;
      pending_q  <= 4'b0000;
      prev_irq_q <= 4'b1111;
      int_q      <= 1'b0;
      vec_q      <= 2'd0;
      data_q     <= 32'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      prev_irq_q <= prev_irq_d;
      int_q      <= int_d;
      vec_q      <= vec_d;
      data_q     <= data_d;
    end
  end

  assign O_int        = int_q;
  assign O_int_vector = vec_q;
  assign O_data       = data_q;

endmodule

// File: tb/tb_ceespu_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ceespu_int_ctrl
//
// Bench for ceespu_int_ctrl: a directed vector table, a reset-during-request
// sequence, and a randomized run against a behavioural model.
// ---------------------------------------------------------------------------
module tb_ceespu_int_ctrl;

  logic        I_clk = 1'b0;
  logic        I_rst_n;
  logic [3:0]  I_irq;
  logic        I_int_ack;
  logic        I_memE;
  logic        I_memWe;
  logic [1:0]  I_addr;
  logic [31:0] I_data;
  logic [31:0] O_data;
  logic        O_int;
  logic [1:0]  O_int_vector;

  int total = 0;
  int bad   = 0;

  ceespu_int_ctrl dut (
    .I_clk        (I_clk),
    .I_rst_n      (I_rst_n),
    .I_irq        (I_irq),
    .I_int_ack    (I_int_ack),
    .I_memE       (I_memE),
    .I_memWe      (I_memWe),
    .I_addr       (I_addr),
    .I_data       (I_data),
    .O_data       (O_data),
    .O_int        (O_int),
    .O_int_vector (O_int_vector)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [3:0]  irq;
    logic        ack;
    logic        e;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        expInt;
    logic [1:0]  expVec;
    logic        chkData;
    logic [31:0] expData;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] irq, logic ack, logic e, logic we,
                              logic [1:0] addr, logic [31:0] wdata,
                              logic expInt, logic [1:0] expVec,
                              logic chkData, logic [31:0] expData);
    vec_t v;
    v.irq = irq; v.ack = ack; v.e = e; v.we = we; v.addr = addr;
    v.wdata = wdata; v.expInt = expInt; v.expVec = expVec;
    v.chkData = chkData; v.expData = expData;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then move to just after the next rising edge.
  task automatic applyStimulus(input logic [3:0] irq, input logic ack,
                               input logic e, input logic we,
                               input logic [1:0] addr, input logic [31:0] wdata);
    I_irq     = irq;
    I_int_ack = ack;
    I_memE    = e;
    I_memWe   = we;
    I_addr    = addr;
    I_data    = wdata;
    @(posedge I_clk);
    #1;
  endtask

  // Behavioural model: per-source bit arrays and a mode number
  // (0 idle, 1 requesting, 2 gap).
  bit          mMask[4];
  bit          mPend[4];
  bit          mPrev[4];
  int          mMode;
  int          mVec;
  logic [31:0] mData;

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mMask[i] = 1'b0;
      mPend[i] = 1'b0;
      mPrev[i] = 1'b1;
    end
    mMode = 0;
    mVec  = 0;
    mData = 32'd0;
  endtask

  task automatic modelStep(input logic [3:0] irq, input logic ack,
                           input logic e, input logic we,
                           input logic [1:0] addr, input logic [31:0] wdata);
    bit ev[4];
    bit clr[4];
    int pendVal;
    int maskVal;
    int nMode;
    int nVec;
    pendVal = 0;
    maskVal = 0;
    for (int i = 0; i < 4; i++) begin
      ev[i]   = irq[i] && !mPrev[i];
      clr[i]  = 1'b0;
      pendVal = pendVal + (int'(mPend[i]) << i);
      maskVal = maskVal + (int'(mMask[i]) << i);
    end
    if (e && !we) begin
      case (addr)
        2'd0:    mData = 32'(maskVal);
        2'd1:    mData = 32'(pendVal);
        2'd2:    mData = 32'(mMode * 16 + ((mMode == 1) ? 8 : 0) + mVec);
        default: mData = 32'd0;
      endcase
    end
    nMode = mMode;
    nVec  = mVec;
    if (mMode == 0) begin
      for (int i = 3; i >= 0; i--) begin
        if (mPend[i] && mMask[i]) begin
          nMode = 1;
          nVec  = i;
        end
      end
    end else if (mMode == 1) begin
      if (ack) begin
        clr[mVec] = 1'b1;
        nMode     = 2;
      end else if (!mMask[mVec] || !mPend[mVec]) begin
        nMode = 0;
      end
    end else begin
      nMode = 0;
    end
    if (e && we && addr == 2'd1) begin
      for (int i = 0; i < 4; i++) if (wdata[i]) clr[i] = 1'b1;
    end
    if (e && we && addr == 2'd0) begin
      for (int i = 0; i < 4; i++) mMask[i] = wdata[i];
    end
    for (int i = 0; i < 4; i++) begin
      if (ev[i]) mPend[i] = 1'b1;
      else if (clr[i]) mPend[i] = 1'b0;
      mPrev[i] = irq[i];
    end
    mMode = nMode;
    mVec  = nVec;
  endtask

  logic [3:0]  rIrq;
  logic        rAck;
  logic        rE;
  logic        rWe;
  logic [1:0]  rAddr;
  logic [31:0] rData;

  initial begin
    // Reset state
    I_rst_n = 1'b0;
    I_irq = 4'h0; I_int_ack = 1'b0; I_memE = 1'b0; I_memWe = 1'b0;
    I_addr = 2'd0; I_data = 32'd0;
    #3;
    checkOutput("reset_int", 32'(O_int), 32'd0);
    checkOutput("reset_vec", 32'(O_int_vector), 32'd0);
    checkOutput("reset_data", O_data, 32'd0);
    #9;
    I_rst_n = 1'b1;

    //            irq  ack e we addr data   int vec chk data
    tbl.push_back(mk(4'h0, 0, 0, 0, 2'd0, 32'h0, 0, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, 1, 2'd0, 32'h4, 0, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h4, 0, 0, 0, 2'd0, 32'h0, 0, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h4, 0, 0, 0, 2'd0, 32'h0, 1, 2'd2, 0, 32'h0));
    tbl.push_back(mk(4'h4, 0, 1, 0, 2'd2, 32'h0, 1, 2'd2, 1, 32'h1A));
    tbl.push_back(mk(4'h4, 1, 0, 0, 2'd0, 32'h0, 0, 2'd2, 0, 32'h0));
    tbl.push_back(mk(4'h4, 0, 1, 0, 2'd1, 32'h0, 0, 2'd2, 1, 32'h0));
    tbl.push_back(mk(4'h4, 0, 1, 0, 2'd2, 32'h0, 0, 2'd2, 1, 32'h02));
    tbl.push_back(mk(4'h4, 0, 1, 1, 2'd0, 32'hF, 0, 2'd2, 0, 32'h0));
    tbl.push_back(mk(4'hE, 0, 0, 0, 2'd0, 32'h0, 0, 2'd2, 0, 32'h0));
    tbl.push_back(mk(4'hE, 0, 0, 0, 2'd0, 32'h0, 1, 2'd1, 0, 32'h0));
    tbl.push_back(mk(4'hE, 1, 0, 0, 2'd0, 32'h0, 0, 2'd1, 0, 32'h0));
    tbl.push_back(mk(4'hE, 0, 0, 0, 2'd0, 32'h0, 0, 2'd1, 0, 32'h0));
    tbl.push_back(mk(4'hE, 0, 0, 0, 2'd0, 32'h0, 1, 2'd3, 0, 32'h0));
    tbl.push_back(mk(4'hF, 0, 0, 0, 2'd0, 32'h0, 1, 2'd3, 0, 32'h0));
    tbl.push_back(mk(4'hF, 0, 0, 0, 2'd0, 32'h0, 1, 2'd3, 0, 32'h0));
    tbl.push_back(mk(4'hF, 1, 0, 0, 2'd0, 32'h0, 0, 2'd3, 0, 32'h0));
    tbl.push_back(mk(4'hF, 0, 1, 0, 2'd1, 32'h0, 0, 2'd3, 1, 32'h1));
    tbl.push_back(mk(4'hF, 0, 0, 0, 2'd0, 32'h0, 1, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'hF, 1, 0, 0, 2'd0, 32'h0, 0, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'hF, 0, 1, 0, 2'd1, 32'h0, 0, 2'd0, 1, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, 1, 2'd0, 32'h0, 0, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h1, 0, 0, 0, 2'd0, 32'h0, 0, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h1, 0, 1, 0, 2'd1, 32'h0, 0, 2'd0, 1, 32'h1));
    tbl.push_back(mk(4'h1, 0, 1, 1, 2'd0, 32'h1, 0, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h1, 0, 0, 0, 2'd0, 32'h0, 1, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h1, 0, 1, 1, 2'd0, 32'h0, 1, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h1, 0, 0, 0, 2'd0, 32'h0, 0, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h1, 0, 1, 0, 2'd1, 32'h0, 0, 2'd0, 1, 32'h1));
    tbl.push_back(mk(4'h5, 0, 1, 1, 2'd1, 32'h4, 0, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h5, 0, 1, 0, 2'd1, 32'h0, 0, 2'd0, 1, 32'h5));
    tbl.push_back(mk(4'h5, 0, 1, 1, 2'd1, 32'hF, 0, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h5, 0, 1, 0, 2'd1, 32'h0, 0, 2'd0, 1, 32'h0));
    tbl.push_back(mk(4'h5, 1, 0, 0, 2'd0, 32'h0, 0, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h5, 0, 1, 0, 2'd2, 32'h0, 0, 2'd0, 1, 32'h0));
    tbl.push_back(mk(4'h5, 0, 1, 1, 2'd3, 32'hF, 0, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h5, 0, 1, 1, 2'd2, 32'hF, 0, 2'd0, 0, 32'h0));
    tbl.push_back(mk(4'h5, 0, 1, 0, 2'd0, 32'h0, 0, 2'd0, 1, 32'h0));
    tbl.push_back(mk(4'h5, 0, 1, 0, 2'd3, 32'h0, 0, 2'd0, 1, 32'h0));
    tbl.push_back(mk(4'h5, 0, 1, 0, 2'd1, 32'h0, 0, 2'd0, 1, 32'h0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].irq, tbl[i].ack, tbl[i].e, tbl[i].we,
                    tbl[i].addr, tbl[i].wdata);
      checkOutput($sformatf("row%0d_int", i), 32'(O_int), 32'(tbl[i].expInt));
      checkOutput($sformatf("row%0d_vec", i), 32'(O_int_vector), 32'(tbl[i].expVec));
      if (tbl[i].chkData)
        checkOutput($sformatf("row%0d_data", i), O_data, tbl[i].expData);
    end

    // Reset asserted mid-request with all lines held high
    applyStimulus(4'h0, 1'b0, 1'b1, 1'b1, 2'd0, 32'hF);
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    checkOutput("pre_reset_int", 32'(O_int), 32'd1);
    #2;
    I_rst_n = 1'b0;
    #1;
    checkOutput("async_reset_int", 32'(O_int), 32'd0);
    #2;
    I_rst_n = 1'b1;
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    applyStimulus(4'hF, 1'b0, 1'b1, 1'b0, 2'd1, 32'h0);
    checkOutput("post_reset_pending", O_data, 32'd0);
    applyStimulus(4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
    checkOutput("post_reset_mask", O_data, 32'd0);
    checkOutput("post_reset_int", 32'(O_int), 32'd0);

    // Randomized run against the model, starting from a fresh reset
    #2;
    I_rst_n = 1'b0;
    I_irq = 4'h0; I_int_ack = 1'b0; I_memE = 1'b0;
    #2;
    I_rst_n = 1'b1;
    modelReset();
    rIrq = 4'h0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0) rIrq = rIrq ^ 4'($urandom);
      rAck  = ($urandom_range(0, 2) == 0);
      rE    = ($urandom_range(0, 1) == 1);
      rWe   = ($urandom_range(0, 1) == 1);
      rAddr = 2'($urandom);
      rData = $urandom;
      modelStep(rIrq, rAck, rE, rWe, rAddr, rData);
      applyStimulus(rIrq, rAck, rE, rWe, rAddr, rData);
      checkOutput($sformatf("rnd%0d_int", n), 32'(O_int), (mMode == 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rnd%0d_vec", n), 32'(O_int_vector), 32'(mVec));
      checkOutput($sformatf("rnd%0d_data", n), O_data, mData);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
